// File: rtl/des_key_scheduler.sv
// DES key schedule generator: streams the 16 round subkeys (K1..K16, or
// K16..K1 when decrypting) over a valid/ready handshake.
// Optional build macro: DES_KEY_PARITY_EN rejects keys whose bytes do not
// all have odd parity; without it parity bits are ignored and key_err is 0.
//
// state | meaning
// IDLE  | waiting for start; C/D hold the last schedule (or zero after reset)
// RUN   | presenting subkey[index]; advances on each handshake
module des_key_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        start,
    input  logic        decrypt,
    output logic        busy,
    output logic [47:0] subkey,
    output logic [3:0]  subkey_round,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        done,
    output logic        key_err
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    // Permuted choice tables in FIPS 46-3 numbering (bit 1 = MSB).
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int j = 0; j < 56; j++)
            r[6'(55 - j)] = k[6'(64 - PC1_TAB[j])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 48; j++)
            r[6'(47 - j)] = cd[6'(56 - PC2_TAB[j])];
        return r;
    endfunction

    // Rotate a 28-bit half by one or two places in either direction.
    function automatic logic [27:0] rot(input logic [27:0] x, input logic left, input logic two);
        logic [27:0] r;
        if (left)
            r = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
        else
            r = two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
        return r;
    endfunction

    // Shift schedule s1..s16: single shift only in rounds 1, 2, 9 and 16.
    function automatic logic shift_is_two(input logic [4:0] n);
        return !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
    endfunction

    state_t      r_state;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_idx;
    logic        r_dec;
    logic        r_done;
    logic        r_key_err;

    logic [55:0] w_pc1;
    logic [4:0]  w_shift_round;
    logic        w_two;
    logic        w_par_bad;

    assign w_pc1 = pc1(key_in);

    // Encrypt steps forward to round idx+2; decrypt undoes round 16-idx.
    assign w_shift_round = r_dec ? (5'd16 - {1'b0, r_idx}) : ({1'b0, r_idx} + 5'd2);
    assign w_two         = shift_is_two(w_shift_round);

`ifdef DES_KEY_PARITY_EN
    // A key is rejected if any byte has even parity.
    always_comb begin
        w_par_bad = 1'b0;
        for (int b = 0; b < 8; b++)
            if (!(^key_in[b*8 +: 8]))
                w_par_bad = 1'b1;
    end
`else
    assign w_par_bad = 1'b0;
`endif

    // Schedule FSM: loads C/D on start, rotates them on each accepted subkey.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_c       <= '0;
            r_d       <= '0;
            r_idx     <= '0;
            r_dec     <= 1'b0;
            r_done    <= 1'b0;
            r_key_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_key_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_par_bad) begin
                            r_key_err <= 1'b1;
                        end else begin
                            r_dec   <= decrypt;
                            r_idx   <= '0;
                            r_state <= S_RUN;
                            // C16/D16 equal C0/D0, so decrypt starts unrotated.
                            if (decrypt) begin
                                r_c <= w_pc1[55:28];
                                r_d <= w_pc1[27:0];
                            end else begin
                                r_c <= rot(w_pc1[55:28], 1'b1, 1'b0);
                                r_d <= rot(w_pc1[27:0], 1'b1, 1'b0);
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (subkey_ready) begin
                        if (r_idx == 4'd15) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                            r_c   <= rot(r_c, !r_dec, w_two);
                            r_d   <= rot(r_d, !r_dec, w_two);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = (r_state == S_RUN);
    assign subkey_valid = (r_state == S_RUN);
    assign subkey_round = r_idx;
    assign subkey       = pc2({r_c, r_d});
    assign done         = r_done;
    assign key_err      = r_key_err;

endmodule
